id_exe_skid_reg: RTL and testbench
==================================

Name: id_exe_skid_reg

Overview:
ID/EXE pipeline boundary register with a 2-entry skid buffer. It captures decoded-instruction fields from the ID stage and presents them to the EXE stage, which contains the val2 generator and the ALU. Both sides use valid/ready handshakes, so an EXE-side stall never drops or duplicates an instruction. The ID side sees a registered ready, which keeps the combinational path short. A synchronous flush kills in-flight instructions on branch-taken.

Parameters:
CTRL_W, 13, width of the bundled control field: exeCmd[3:0], memRead, memWrite, wbEn, dest[3:0], sBit, plus 1 spare bit.
CNT_W, 16, width of the bubble counter (optional feature only).

Ports:
clk  in  1  pipeline clock, rising edge.
rst  in  1  asynchronous, active-low reset.
flush  in  1  synchronous kill of all held entries (branch taken).
inValid  in  1  ID stage presents a valid instruction.
inReady  out  1  register can accept; registered, equals NOT skidValid.
inPc  in  32  PC+4 of the instruction.
inRnVal  in  32  Rn operand value.
inRmVal  in  32  Rm operand value; feeds RMVal of val2 generator.
inImm  in  1  immediate flag; feeds Imm.
inLdOrStr  in  1  load/store flag; feeds LdOrStr.
inShiftOperand  in  12  shifter operand field; feeds ShiftOperand.
inStatus  in  4  NZCV flags at decode.
inCtrl  in  CTRL_W  bundled control.
outValid  out  1  EXE-side entry valid.
outReady  in  1  EXE stage consumes this cycle.
outPc, outRnVal, outRmVal, outImm, outLdOrStr, outShiftOperand, outStatus, outCtrl  out  same widths as inputs  registered payload.
bubbleCnt  out  CNT_W  bubble count; 0 when feature is off.

Behaviour:
- Storage: main entry (drives out*) and skid entry. Each has a valid bit.
- Reset (rst low, async): mainValid=0, skidValid=0, all payload regs=0, inReady=1, bubbleCnt=0.
- accept = inValid & inReady. drain = outValid & outReady.
- Per-cycle update, evaluated in priority order:
  - flush=1: mainValid<=0 and skidValid<=0. Any input accepted this cycle is discarded. inReady=1 next cycle. Payload regs hold their values.
  - main empty, or drain: if skidValid, skid->main and skidValid<=0, then accept (if any) loads skid. Else accept loads main directly.
  - main full and no drain: accept loads skid and sets skidValid.
- Order is strictly FIFO. The skid entry is never overwritten while valid; inReady=0 guarantees this.
- Latency: input accepted in cycle N appears on out* in cycle N+1 when the pipe is empty. Full throughput is 1/cycle with outReady held high.
- Payload regs load only on a write into the entry; otherwise they hold, so there is no toggle on bubbles.
- inValid while inReady=0 is legal. The input is ignored and ID must hold it.
- out* are stable while outValid=1 and outReady=0.
- Reset asserted mid-transfer clears everything immediately, independent of clk.

Optional Feature:
Macro ID_EXE_BUBBLE_CNT_EN.
- Defined: bubbleCnt increments by 1 on every cycle with outReady=1 and outValid=0. It saturates at all-ones and does not wrap. It clears on reset only; flush does not clear it.
- Undefined: no counter logic is built, and bubbleCnt is tied to 0.

Test Plan:
- Reset then idle -> all outputs 0, inReady=1, outValid=0; release rst -> inReady stays 1.
- Streaming: 4 instructions with inRmVal=0x11,0x22,0x33,0x44 back-to-back, outReady=1 -> outRmVal 0x11..0x44 on consecutive cycles, 1-cycle latency, inReady always 1.
- Stall: outReady=0 with inValid=1 streaming 0xA,0xB,0xC -> main=0xA, skid=0xB, inReady=0 one cycle after skid fill; 0xC held. Then outReady=1 -> outputs 0xA,0xB,0xC in order, with no loss or duplicate.
- Flush with both entries full and inValid=1 -> next cycle outValid=0, inReady=1. Next accepted value (0x55) appears as the first output.
- Async reset asserted mid-stall, between edges -> outValid and inReady-derived state clear immediately, without waiting for a clock edge.
- ID_EXE_BUBBLE_CNT_EN defined: 10 cycles with outReady=1 and inValid=0 -> bubbleCnt=10. With the counter preset near saturation, it stops at 0xFFFF. Undefined: bubbleCnt stays 0.

Source files
------------

// File: rtl/id_exe_skid_reg.sv
// ID/EXE boundary register: main entry plus one skid entry, valid/ready on both sides.
// Optional saturating bubble counter is built only when ID_EXE_BUBBLE_CNT_EN is defined.
module id_exe_skid_reg #(
  parameter int CTRL_W = 13,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              inValid,
  output logic              inReady,
  input  logic [31:0]       inPc,
  input  logic [31:0]       inRnVal,
  input  logic [31:0]       inRmVal,
  input  logic              inImm,
  input  logic              inLdOrStr,
  input  logic [11:0]       inShiftOperand,
  input  logic [3:0]        inStatus,
  input  logic [CTRL_W-1:0] inCtrl,
  output logic              outValid,
  input  logic              outReady,
  output logic [31:0]       outPc,
  output logic [31:0]       outRnVal,
  output logic [31:0]       outRmVal,
  output logic              outImm,
  output logic              outLdOrStr,
  output logic [11:0]       outShiftOperand,
  output logic [3:0]        outStatus,
  output logic [CTRL_W-1:0] outCtrl,
  output logic [CNT_W-1:0]  bubbleCnt
);

  localparam int PW = 32 + 32 + 32 + 1 + 1 + 12 + 4 + CTRL_W;

  logic [PW-1:0] in_pay_s;
  logic          accept_s;
  logic          drain_s;

  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [PW-1:0] main_pay_q, main_pay_d;
  logic [PW-1:0] skid_pay_q, skid_pay_d;

  assign in_pay_s = {inPc, inRnVal, inRmVal, inImm, inLdOrStr, inShiftOperand, inStatus, inCtrl};
  assign accept_s = inValid & inReady;
  assign drain_s  = main_valid_q & outReady;

  // Entry update: flush first, then refill main (from skid if occupied), else park input in skid.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_pay_d   = main_pay_q;
    skid_pay_d   = skid_pay_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain_s) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_pay_d   = skid_pay_q;
        skid_valid_d = accept_s;
        if (accept_s) begin
          skid_pay_d = in_pay_s;
        end else begin
          skid_pay_d = skid_pay_q;
        end
      end else begin
        main_valid_d = accept_s;
        if (accept_s) begin
          main_pay_d = in_pay_s;
        end else begin
          main_pay_d = main_pay_q;
        end
      end
    end else begin
      if (accept_s) begin
        skid_valid_d = 1'b1;
        skid_pay_d   = in_pay_s;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
  end

  // Entry state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_pay_q   <= '0;
      skid_pay_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_pay_q   <= main_pay_d;
      skid_pay_q   <= skid_pay_d;
    end
  end

  // inReady comes straight from a flop, so ID never sees a path through outReady.
  assign inReady  = ~skid_valid_q;
  assign outValid = main_valid_q;
  assign {outPc, outRnVal, outRmVal, outImm, outLdOrStr, outShiftOperand, outStatus, outCtrl} = main_pay_q;

`ifdef ID_EXE_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_q, bubble_d;

  // Count cycles where EXE was ready but had nothing to take; saturate, never wrap.
  always_comb begin
    bubble_d = bubble_q;
    if (outReady && !main_valid_q && !(&bubble_q)) begin
      bubble_d = bubble_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_d = bubble_q;
    end
  end

  // Bubble counter register; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_q <= '0;
    end else begin
      bubble_q <= bubble_d;
    end
  end

  assign bubbleCnt = bubble_q;
`else
  assign bubbleCnt = '0;
`endif

endmodule

// File: tb/tb_id_exe_skid_reg.sv
// Scoreboard bench for id_exe_skid_reg: directed scenarios plus randomized traffic
// against a queue model of the held instructions (bubble check follows ID_EXE_BUBBLE_CNT_EN).
module tb_id_exe_skid_reg;

  localparam int CTRL_W = 13;
  localparam int CNT_W  = 5;
  localparam int PW     = 32 + 32 + 32 + 1 + 1 + 12 + 4 + CTRL_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              inValid = 1'b0;
  logic              inReady;
  logic [31:0]       inPc = 32'd0, inRnVal = 32'd0, inRmVal = 32'd0;
  logic              inImm = 1'b0, inLdOrStr = 1'b0;
  logic [11:0]       inShiftOperand = 12'd0;
  logic [3:0]        inStatus = 4'd0;
  logic [CTRL_W-1:0] inCtrl = '0;
  logic              outValid;
  logic              outReady = 1'b0;
  logic [31:0]       outPc, outRnVal, outRmVal;
  logic              outImm, outLdOrStr;
  logic [11:0]       outShiftOperand;
  logic [3:0]        outStatus;
  logic [CTRL_W-1:0] outCtrl;
  logic [CNT_W-1:0]  bubbleCnt;

  id_exe_skid_reg #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inValid(inValid), .inReady(inReady),
    .inPc(inPc), .inRnVal(inRnVal), .inRmVal(inRmVal), .inImm(inImm),
    .inLdOrStr(inLdOrStr), .inShiftOperand(inShiftOperand), .inStatus(inStatus), .inCtrl(inCtrl),
    .outValid(outValid), .outReady(outReady),
    .outPc(outPc), .outRnVal(outRnVal), .outRmVal(outRmVal), .outImm(outImm),
    .outLdOrStr(outLdOrStr), .outShiftOperand(outShiftOperand), .outStatus(outStatus), .outCtrl(outCtrl),
    .bubbleCnt(bubbleCnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instructions the pipe register currently holds, oldest first.
  logic [PW-1:0]    held[$];
  logic             pend_acc = 1'b0;
  logic [PW-1:0]    pend_pay = '0;
  logic [CNT_W-1:0] bub_m = '0;
  logic             chk_en = 1'b0;

  task automatic chk(input string nm, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] out_pay();
    return {outPc, outRnVal, outRmVal, outImm, outLdOrStr, outShiftOperand, outStatus, outCtrl};
  endfunction

  function automatic logic [PW-1:0] mk_pay(input logic [31:0] rm);
    logic [31:0]       pc, rn;
    logic [11:0]       sh;
    logic [3:0]        st;
    logic [CTRL_W-1:0] ct;
    logic [1:0]        fl;
    pc = $urandom(); rn = $urandom();
    sh = 12'($urandom()); st = 4'($urandom()); ct = CTRL_W'($urandom()); fl = 2'($urandom());
    return {pc, rn, rm, fl, sh, st, ct};
  endfunction

  // Monitor: compare DUT against the model, then advance the model through the coming edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("inReady", PW'(inReady), PW'(held.size() < 2));
      chk("outValid", PW'(outValid), PW'(held.size() > 0));
      chk("bubbleCnt", PW'(bubbleCnt), PW'(bub_m));
      if (held.size() > 0) chk("payload", out_pay(), held[0]);
`ifdef ID_EXE_BUBBLE_CNT_EN
      if (outReady && held.size() == 0 && bub_m != CNT_MAX) bub_m = bub_m + 1'b1;
`endif
      if (flush) begin
        held.delete();
      end else begin
        if (outReady && held.size() > 0) void'(held.pop_front());
        if (pend_acc) held.push_back(pend_pay);
      end
    end
  end

  // One cycle of stimulus; acceptance follows the rule that ID may push while fewer than two are held.
  task automatic cyc(input logic v, input logic r, input logic f, input logic [PW-1:0] p);
    inValid = v; outReady = r; flush = f;
    {inPc, inRnVal, inRmVal, inImm, inLdOrStr, inShiftOperand, inStatus, inCtrl} = p;
    pend_acc = v && !f && (held.size() < 2);
    pend_pay = p;
    @(posedge clk); #1;
  endtask

  logic [PW-1:0] p;
  logic          got;

  initial begin
    // Reset asserted before any clock edge.
    #1;
    chk("rst_outValid", PW'(outValid), PW'(0));
    chk("rst_inReady", PW'(inReady), PW'(1));
    chk("rst_payload", out_pay(), '0);
    chk("rst_bubble", PW'(bubbleCnt), PW'(0));
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rel_inReady", PW'(inReady), PW'(1));
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Idle with EXE ready: bubble count.
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, '0);
`ifdef ID_EXE_BUBBLE_CNT_EN
    chk("bubble10", PW'(bubbleCnt), PW'(10));
`else
    chk("bubble_off", PW'(bubbleCnt), PW'(0));
`endif

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, 1'b0, mk_pay(32'(i * 32'h11)));
    cyc(1'b0, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, '0);

    // Stall: fill main and skid, hold the third until accepted.
    cyc(1'b1, 1'b0, 1'b0, mk_pay(32'hA));
    cyc(1'b1, 1'b0, 1'b0, mk_pay(32'hB));
    p = mk_pay(32'hC);
    cyc(1'b1, 1'b0, 1'b0, p);
    chk("stall_inReady", PW'(inReady), PW'(0));
    chk("stall_head", PW'(outRmVal), PW'(32'hA));
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      got = (held.size() < 2);
      cyc(1'b1, 1'b1, 1'b0, p);
    end
    chk("stall_C_accepted", PW'(got), PW'(1));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, '0);

    // Flush with both entries full and a new input offered.
    cyc(1'b1, 1'b0, 1'b0, mk_pay(32'h1));
    cyc(1'b1, 1'b0, 1'b0, mk_pay(32'h2));
    cyc(1'b1, 1'b0, 1'b1, mk_pay(32'h3));
    chk("flush_outValid", PW'(outValid), PW'(0));
    chk("flush_inReady", PW'(inReady), PW'(1));
    cyc(1'b1, 1'b0, 1'b0, mk_pay(32'h55));
    chk("flush_first", PW'(outRmVal), PW'(32'h55));
    cyc(1'b0, 1'b1, 1'b0, '0);

    // Async reset mid-stall, between clock edges.
    cyc(1'b1, 1'b0, 1'b0, mk_pay(32'h66));
    cyc(1'b1, 1'b0, 1'b0, mk_pay(32'h77));
    inValid = 1'b0; pend_acc = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("arst_outValid", PW'(outValid), PW'(0));
    chk("arst_inReady", PW'(inReady), PW'(1));
    chk("arst_payload", out_pay(), '0);
    chk("arst_bubble", PW'(bubbleCnt), PW'(0));
    held.delete();
    bub_m = '0;
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      cyc(1'b1 & ($urandom_range(0, 3) != 0), 1'(($urandom_range(0, 2) != 0)),
          1'($urandom_range(0, 24) == 0), mk_pay($urandom()));
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    chk("drained", PW'(outValid), PW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
